// File: rtl/mem_loader.sv
// Stream-to-RAM program loader: writes a valid/ready byte stream into program RAM,
// or in verify mode reads RAM back and counts mismatches against the stream.
module mem_loader #(
   parameter int AW = 16,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] len,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_write,
   output logic          mem_read,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          done,
   output logic [7:0]    err_cnt,
   output logic [AW-1:0] first_err_addr,
   output logic          err_flag
);

   typedef enum logic [2:0] {IDLE, FETCH, WRITE, READ, CHECK, DONE} state_t;

   localparam logic [AW-1:0] ONE = 1;

   state_t        state;
   logic          mode_q;
   logic [AW-1:0] len_q;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_inc;
   logic          last;

   assign cnt_inc = cnt + ONE;
   assign last    = (cnt_inc == len_q);

   // mem_addr doubles as the running address and mem_wdata as the byte register,
   // so both are already registered and stable through the strobe cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         mode_q         <= 1'b0;
         len_q          <= '0;
         cnt            <= '0;
         in_ready       <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         mem_write      <= 1'b0;
         mem_read       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
         err_flag       <= 1'b0;
      end else begin
         done      <= 1'b0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q         <= mode;
                  len_q          <= len;
                  mem_addr       <= base_addr;
                  cnt            <= '0;
                  err_cnt        <= '0;
                  err_flag       <= 1'b0;
                  first_err_addr <= '0;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= FETCH;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (in_valid) begin
                  mem_wdata <= in_data;
                  in_ready  <= 1'b0;
                  if (mode_q) begin
                     state    <= READ;
                     mem_read <= 1'b1;
                  end else begin
                     state     <= WRITE;
                     mem_write <= 1'b1;
                  end
               end
            end
            READ: state <= CHECK;
            // WRITE and CHECK share the address/count advance; only CHECK compares.
            WRITE, CHECK: begin
               if (state == CHECK && mem_rdata != mem_wdata) begin
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                  if (!err_flag) begin
                     err_flag       <= 1'b1;
                     first_err_addr <= mem_addr;
                  end
               end
               mem_addr <= mem_addr + ONE;
               cnt      <= cnt_inc;
               if (last) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state    <= FETCH;
                  in_ready <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: behavioural RAM, strobe monitor and hand-computed
// expectations for load, verify, backpressure, wrap, saturation and reset cases.
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        rst, start, mode, in_valid, in_ready;
   logic [15:0] base_addr, len, mem_addr, first_err_addr;
   logic [7:0]  in_data, mem_wdata, mem_rdata, err_cnt;
   logic        mem_write, mem_read, busy, done, err_flag;

   int          n_checks = 0;
   int          n_fails = 0;
   int          strobe_viol = 0;
   int          dc;
   logic        busy_at1;
   logic        prev_w = 1'b0;
   logic        prev_r = 1'b0;
   logic [7:0]  ram [0:65535];
   logic [7:0]  stream [$];
   logic [23:0] wlog [$];

   always #5 clk = ~clk;

   mem_loader #(.AW(16), .DW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
      .len(len), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy), .done(done),
      .err_cnt(err_cnt), .first_err_addr(first_err_addr), .err_flag(err_flag)
   );

   // RAM model: synchronous write, read data valid the cycle after mem_read.
   always @(posedge clk) begin
      if (mem_write) ram[mem_addr] <= mem_wdata;
      if (mem_read) mem_rdata <= ram[mem_addr];
   end

   always @(negedge clk) begin
      if (mem_write) wlog.push_back({mem_addr, mem_wdata});
      if ((mem_write && mem_read) || (mem_write && prev_w) || (mem_read && prev_r) ||
          (in_ready && (mem_write || mem_read || done)))
         strobe_viol++;
      prev_w = mem_write;
      prev_r = mem_read;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkWrites(input string tag, input logic [15:0] base);
      logic [15:0] a;
      checkOutput({tag, "_nwrites"}, wlog.size(), stream.size());
      for (int i = 0; i < stream.size(); i++) begin
         a = base + 16'(i);
         if (i < wlog.size()) checkOutput({tag, "_write"}, wlog[i], {a, stream[i]});
      end
   endtask

   // One start pulse, then streams the queue with the chosen valid pattern until done.
   task automatic applyStimulus(input logic m, input logic [15:0] base, input logic [15:0] n,
                                input int pattern, input int abort_writes, input logic mid_start,
                                output int done_cycle);
      int   idx;
      logic acc;
      idx = 0;
      acc = 1'b0;
      done_cycle = -1;
      wlog.delete();
      @(negedge clk);
      start = 1'b1; mode = m; base_addr = base; len = n;
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (mid_start && c == 3) begin
            start = 1'b1; mode = ~m; base_addr = 16'h7777; len = 16'd1;
         end
         if (c == 1) busy_at1 = busy;
         if (done) begin
            done_cycle = c;
            break;
         end
         if (abort_writes > 0 && wlog.size() >= abort_writes) begin
            done_cycle = c;
            break;
         end
         if (acc) idx++;
         in_valid = (idx < stream.size() && (pattern == 0 || c % 4 == 0 || c % 4 == 3)) ? 1'b1 : 1'b0;
         in_data  = in_valid ? stream[idx] : 8'h5A;
         acc      = in_valid && in_ready;
      end
      in_valid = 1'b0;
      start = 1'b0;
      if (done_cycle < 0) checkOutput("timeout", 1, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; len = '0;
      in_data = '0; in_valid = 1'b0; busy_at1 = 1'b0;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      #12;
      checkOutput("rst_ctl", {in_ready, busy, done, mem_write, mem_read, err_flag}, 0);
      checkOutput("rst_addr", {mem_addr, mem_wdata}, 0);
      checkOutput("rst_err", {err_cnt, first_err_addr}, 0);
      @(negedge clk);
      rst = 1'b0;

      stream = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      applyStimulus(1'b0, 16'h0010, 16'd4, 0, 0, 1'b0, dc);
      checkOutput("load_done_cycle", dc, 9);
      checkOutput("load_busy", busy_at1, 1);
      checkOutput("load_err_cnt", err_cnt, 0);
      checkWrites("load", 16'h0010);

      stream = '{8'hA1, 8'hB2, 8'h00, 8'hD4};
      applyStimulus(1'b1, 16'h0010, 16'd4, 0, 0, 1'b0, dc);
      checkOutput("verify_done_cycle", dc, 13);
      checkOutput("verify_nwrites", wlog.size(), 0);
      checkOutput("verify_err_cnt", err_cnt, 1);
      checkOutput("verify_err_flag", err_flag, 1);
      checkOutput("verify_first_err", first_err_addr, 16'h0012);
      repeat (2) @(negedge clk);
      checkOutput("verify_hold", {err_cnt, err_flag, first_err_addr}, {8'd1, 1'b1, 16'h0012});

      stream.delete();
      applyStimulus(1'b0, 16'h0050, 16'd0, 0, 0, 1'b0, dc);
      checkOutput("zero_done_cycle", dc, 1);
      checkOutput("zero_busy", busy_at1, 0);
      checkOutput("zero_nwrites", wlog.size(), 0);
      checkOutput("zero_err_clear", {err_cnt, err_flag, first_err_addr}, 0);

      stream = '{8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(1'b0, 16'h0040, 16'd4, 1, 0, 1'b0, dc);
      checkOutput("bp_done_cycle", dc, 17);
      checkWrites("bp", 16'h0040);

      stream = '{8'h11, 8'h22, 8'h33};
      applyStimulus(1'b0, 16'hFFFE, 16'd3, 0, 0, 1'b0, dc);
      checkOutput("wrap_done_cycle", dc, 7);
      checkWrites("wrap", 16'hFFFE);

      stream.delete();
      repeat (300) stream.push_back(8'hFF);
      applyStimulus(1'b1, 16'h0100, 16'd300, 0, 0, 1'b1, dc);
      checkOutput("sat_done_cycle", dc, 901);
      checkOutput("sat_err_cnt", err_cnt, 255);
      checkOutput("sat_first_err", first_err_addr, 16'h0100);
      checkOutput("sat_err_flag", err_flag, 1);

      stream = '{8'h91, 8'h92, 8'h93, 8'h94};
      applyStimulus(1'b0, 16'h0020, 16'd4, 0, 2, 1'b0, dc);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_ctl", {in_ready, busy, done, mem_write, mem_read, err_flag}, 0);
      checkOutput("midrst_addr", {mem_addr, mem_wdata}, 0);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_ram", {ram[16'h0020], ram[16'h0021], ram[16'h0022]}, 24'h919200);

      stream = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      applyStimulus(1'b0, 16'h0030, 16'd4, 0, 0, 1'b0, dc);
      checkOutput("after_rst_done_cycle", dc, 9);
      checkWrites("after_rst", 16'h0030);

      checkOutput("strobe_rules", strobe_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
# mem_loader

Stream-to-RAM program loader and verifier for the 8-bit CPU system. It accepts a byte stream through a valid/ready handshake and writes it into the program RAM, taking the place of manual switch entry. In verify mode it instead reads the RAM back and compares each location against the stream. It sits beside the CPU on the RAM address, data and strobe lines, and is only enabled while the CPU is in its load state.

## Interface
Parameters:
- AW, 16, RAM address width; matches the 16-bit CPU address bus.
- DW, 8, data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle start pulse; sampled only in IDLE.
- mode  in  1  0 = load (write), 1 = verify (read and compare); latched at start.
- base_addr  in  AW  first RAM address; latched at start.
- len  in  AW  number of bytes to transfer; latched at start.
- in_data  in  DW  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader can accept a byte.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_write  out  1  one-cycle write strobe.
- mem_read  out  1  one-cycle read strobe.
- mem_rdata  in  DW  RAM read data; valid the cycle after mem_read.
- busy  out  1  high from the accepted start until DONE.
- done  out  1  one-cycle completion pulse.
- err_cnt  out  8  verify mismatch count; saturates at 255.
- first_err_addr  out  AW  address of the first mismatch.
- err_flag  out  1  at least one mismatch in the last verify run.

## Operation
- States: IDLE, FETCH, WRITE, READ, CHECK, DONE.
- IDLE:
  - start=1 latches mode, base_addr and len.
  - Clears the internal byte counter cnt, err_cnt, err_flag and first_err_addr.
  - Goes to DONE if len==0, otherwise to FETCH.
- FETCH:
  - in_ready=1.
  - On in_valid & in_ready, latches in_data into a byte register, then goes to WRITE (mode 0) or READ (mode 1).
  - Stalls indefinitely while in_valid=0.
- WRITE:
  - mem_write=1, mem_addr=current address, mem_wdata=byte register.
  - Address +1 and cnt +1.
  - Goes to DONE if cnt+1==len, else to FETCH.
- READ:
  - mem_read=1, mem_addr=current address.
  - Goes to CHECK.
- CHECK:
  - Compares mem_rdata with the byte register.
  - On mismatch: err_cnt+1 (saturating); if err_flag was 0, sets err_flag and captures first_err_addr = current address.
  - Address +1 and cnt +1.
  - Goes to DONE if cnt+1==len, else to FETCH.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Address arithmetic is modulo 2^AW, so 0xFFFF+1 wraps to 0x0000. cnt is AW bits wide.
- Edge cases:
  - start outside IDLE is ignored.
  - in_data/in_valid outside FETCH are ignored; in_ready is 0 there.
  - mem_write and mem_read are never high together, and each is never high for two consecutive cycles.
- Reset mid-operation: every register returns to its reset value and the FSM goes to IDLE. A partially written RAM is left as is.
- err_cnt, err_flag and first_err_addr hold their values after DONE until the next accepted start.

## Timing
- Reset values:
  - state=IDLE.
  - in_ready, mem_write, mem_read, busy, done, err_flag = 0.
  - mem_addr, mem_wdata, err_cnt, first_err_addr = 0.
- busy rises the cycle after the accepted start.
- Load throughput: 2 cycles per byte with in_valid held high (FETCH, WRITE).
- Verify throughput: 3 cycles per byte (FETCH, READ, CHECK).
- done asserts the cycle after the last WRITE or CHECK. For len==0, done asserts the cycle after start.
- mem_addr and mem_wdata are registered and stable for the whole strobe cycle.
- mem_rdata is sampled in CHECK, exactly one cycle after mem_read.

## Test plan
- Load: mode=0, base=0x0010, len=4, stream 0xA1,0xB2,0xC3,0xD4 with in_valid held high -> writes at 0x10–0x13 with those values, one strobe each 2 cycles, done 9 cycles after start, err_cnt=0.
- Verify pass and fail: after the load above, mode=1 with the same stream except byte 3 = 0x00 -> err_cnt=1, err_flag=1, first_err_addr=0x0012, done asserted.
- Backpressure: in_valid toggles 1,0,0,1 -> no mem_write while in_valid=0, byte order preserved, in_ready high only in FETCH.
- Wrap and zero length: base=0xFFFE, len=3 -> writes at 0xFFFE, 0xFFFF, 0x0000. len=0 -> done the cycle after start, no strobes.
- Saturation and ignored start: verify 300 mismatching bytes -> err_cnt=255. A start pulse mid-run -> no effect on state or latched parameters.
- Reset mid-load: assert rst after 2 of 4 bytes -> all outputs 0 immediately, FSM in IDLE. A following start runs normally from base_addr.
